bypass_scoreboard: RTL and testbench
====================================

# bypass_scoreboard

Parametrised operand-bypass and hazard unit for the Mini-RISC-V integer pipeline, placed between the register file read and the EX-stage operand muxes. Selects each of NSRC source operands from the youngest matching bypass stage, a long-latency completion port, or the register file. Tracks in-flight long-latency writers (loads on slow memory, mul/div) in a per-register scoreboard and raises `stall` on RAW/WAW hazards. Replaces the fixed two-operand, three-stage forwarding mux.

## Interface
- `XLEN`, 32, data width
- `NSRC`, 2, source operand ports
- `NBYP`, 3, bypass channels; index 0 is youngest (EX/MEM), NBYP-1 oldest (WB)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `issue_valid`  in  1  instruction in ID is attempting issue this cycle
- `issue_rd`  in  5  its destination register
- `issue_we`  in  1  it writes `issue_rd`
- `issue_long`  in  1  its result returns via the completion port
- `issue_rs`  in  NSRC×5  source register indices
- `rf_data`  in  NSRC×XLEN  register file read data
- `byp_valid`  in  NBYP  channel holds a register-writing instruction
- `byp_ready`  in  NBYP  channel data is final (0 for a load still in MEM)
- `byp_rd`  in  NBYP×5  channel destination
- `byp_data`  in  NBYP×XLEN  channel result
- `done_valid`  in  1  long-latency result returning
- `done_rd`  in  5  its destination
- `done_data`  in  XLEN  its result
- `flush`  in  1  cancel the issuing instruction
- `opnd`  out  NSRC×XLEN  resolved operands
- `stall`  out  1  hold ID; issue does not occur
- `sb_busy`  out  32  scoreboard state, bit 0 always 0

## Operation
- Operand select per source s, priority order: `issue_rs[s]==0` → 0; `done_valid && done_rd==rs` → `done_data`; lowest index i with `byp_valid[i] && byp_rd[i]==rs` → `byp_data[i]`; else `rf_data[s]`.
- RAW stall: any s with `rs!=0` where the selected bypass channel has `byp_ready[i]==0`, or `sb_busy[rs]==1` and not satisfied by `done` this cycle.
- WAW stall: `issue_we && issue_long && sb_busy[issue_rd]` and not cleared by `done` this cycle.
- `stall` only asserted when `issue_valid`.
- Issue fires when `issue_valid && !stall && !flush`.
- Scoreboard, next cycle: set bit `issue_rd` on fire with `issue_we && issue_long && issue_rd!=0`; clear bit `done_rd` on `done_valid`. Set and clear of the same bit in one cycle: set wins.
- `flush` never clears the scoreboard; in-flight long ops still return.
- `done_valid` for a non-busy register: data still forwarded, scoreboard unchanged.
- x0 is never busy and never forwarded.

## Timing
- `opnd` and `stall` are combinational from inputs and current `sb_busy`, with zero-cycle latency.
- Scoreboard updates take effect on the next `clk` edge, so a dependent instruction issued the cycle after a long op sees busy=1.
- Reset: `sb_busy` = 0. With inputs idle, `stall` = 0 and `opnd` = `rf_data`.
- `rst` asserted mid-operation clears all busy bits at the edge, and outstanding `done` returns are then harmless.

## Configuration
- `BYPASS_PERF_EN` defined: adds outputs `perf_raw_stalls` and `perf_waw_stalls` (32 bit each). They count cycles with `stall` caused by RAW and WAW hazards respectively; a cycle with both hazards increments both. They saturate at all-ones and reset to 0.
- Undefined: no counters and no ports.

## Structure
- Shared package `bypass_pkg`: `regidx_t` (logic [4:0]), `REG_ZERO`, and the function `byp_match(valid, rd, rs)`.
- One sub-module `bypass_sel`, instantiated NSRC times. It is a per-operand priority mux that returns data plus a not-ready flag. The scoreboard and stall logic live in the top.

## Test plan
- Reset, then `issue_rs={5,6}` with `byp_valid=0` → `opnd` equals `rf_data`, `stall`=0, `sb_busy`=0.
- `byp_valid=3'b011`, `byp_rd={7,7,-}`, data 0xAAAA (ch0) and 0xBBBB (ch1), `issue_rs[0]=7` → `opnd[0]`=0xAAAA (youngest wins). `issue_rs[1]=0` with `byp_rd[0]=0` → `opnd[1]`=0.
- Load in ch0 (`byp_ready[0]=0`, rd=9), `issue_rs[0]=9` → `stall`=1 for one cycle. Next cycle the load moves to ch1 ready=1 → `opnd[0]`=load data, `stall`=0.
- Issue mul with rd=12 long → next cycle `sb_busy[12]`=1. Use of x12 stalls until `done_valid` with `done_rd=12`, `done_data=0x1234`; that same cycle `stall`=0 and `opnd`=0x1234; the following cycle `sb_busy[12]`=0.
- Second long op to rd=12 while busy → WAW `stall`. Same cycle `done_rd=12` plus fire → `sb_busy[12]` stays 1.
- `flush` with a long issue → no bit set. `rst` while bits 3 and 4 are busy → `sb_busy`=0 the next cycle. With `BYPASS_PERF_EN`, 3 RAW-stall cycles → `perf_raw_stalls`=3.

Source files
------------

// File: rtl/bypass_pkg.sv
// Shared types and helpers for the operand bypass / hazard scoreboard.
package bypass_pkg;
  typedef logic [4:0] regidx_t;

  localparam regidx_t REG_ZERO = 5'd0;
  localparam int      NREGS    = 32;

  // A producer matches a source only when it is valid and the register is not x0.
  function automatic logic byp_match(input logic valid, input regidx_t rd, input regidx_t rs);
    return valid && (rd == rs) && (rs != REG_ZERO);
  endfunction
endpackage

// File: rtl/bypass_sel.sv
// Per-operand priority mux: x0, then completion port, then youngest bypass channel, then RF.
module bypass_sel
  import bypass_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NBYP = 3
) (
  input  regidx_t                    rs,
  input  logic [XLEN-1:0]            rf_data,
  input  logic [NBYP-1:0]            byp_valid,
  input  logic [NBYP-1:0]            byp_ready,
  input  logic [NBYP-1:0][4:0]       byp_rd,
  input  logic [NBYP-1:0][XLEN-1:0]  byp_data,
  input  logic                       done_valid,
  input  regidx_t                    done_rd,
  input  logic [XLEN-1:0]            done_data,
  output logic [XLEN-1:0]            data,
  output logic                       not_ready,
  output logic                       done_hit
);
  always_comb begin
    data      = rf_data;
    not_ready = 1'b0;
    done_hit  = byp_match(done_valid, done_rd, rs);
    if (rs == REG_ZERO) begin
      data = '0;
    end else if (done_hit) begin
      data = done_data;
    end else begin
      // Walk oldest to youngest so the lowest matching index is the one left standing.
      for (int i = NBYP - 1; i >= 0; i--) begin
        if (byp_match(byp_valid[i], byp_rd[i], rs)) begin
          data      = byp_data[i];
          not_ready = !byp_ready[i];
        end
      end
    end
  end
endmodule

// File: rtl/bypass_scoreboard.sv
// Operand bypass selection plus long-latency writer scoreboard and RAW/WAW stall.
// Optional stall counters are built when BYPASS_PERF_EN is defined.
module bypass_scoreboard
  import bypass_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int NBYP = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  regidx_t                    issue_rd,
  input  logic                       issue_we,
  input  logic                       issue_long,
  input  logic [NSRC-1:0][4:0]       issue_rs,
  input  logic [NSRC-1:0][XLEN-1:0]  rf_data,
  input  logic [NBYP-1:0]            byp_valid,
  input  logic [NBYP-1:0]            byp_ready,
  input  logic [NBYP-1:0][4:0]       byp_rd,
  input  logic [NBYP-1:0][XLEN-1:0]  byp_data,
  input  logic                       done_valid,
  input  regidx_t                    done_rd,
  input  logic [XLEN-1:0]            done_data,
  input  logic                       flush,
  output logic [NSRC-1:0][XLEN-1:0]  opnd,
  output logic                       stall,
  output logic [NREGS-1:0]           sb_busy
`ifdef BYPASS_PERF_EN
  ,
  output logic [31:0]                perf_raw_stalls,
  output logic [31:0]                perf_waw_stalls
`endif
);
  logic [NREGS-1:0] sb_q, sb_d;
  logic [NSRC-1:0]  nr, dh, raw_s;
  logic             raw_hz, waw_hz, fire;

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    bypass_sel #(.XLEN(XLEN), .NBYP(NBYP)) u_sel (
      .rs         (issue_rs[s]),
      .rf_data    (rf_data[s]),
      .byp_valid  (byp_valid),
      .byp_ready  (byp_ready),
      .byp_rd     (byp_rd),
      .byp_data   (byp_data),
      .done_valid (done_valid),
      .done_rd    (done_rd),
      .done_data  (done_data),
      .data       (opnd[s]),
      .not_ready  (nr[s]),
      .done_hit   (dh[s])
    );
    // A busy source is fine if its completion arrives this very cycle.
    assign raw_s[s] = nr[s] | (sb_q[issue_rs[s]] & ~dh[s]);
  end

  assign raw_hz = |raw_s;
  assign waw_hz = issue_we && issue_long && sb_q[issue_rd]
                  && !byp_match(done_valid, done_rd, issue_rd);
  assign stall  = issue_valid && (raw_hz || waw_hz);
  assign fire   = issue_valid && !stall && !flush;

  always_comb begin
    sb_d = sb_q;
    if (done_valid) sb_d[done_rd] = 1'b0;
    // Set after clear: a re-issue to the returning register stays busy.
    if (fire && issue_we && issue_long && issue_rd != REG_ZERO) sb_d[issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  assign sb_busy = sb_q;

`ifdef BYPASS_PERF_EN
  logic [31:0] raw_cnt_q, waw_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_cnt_q <= '0;
      waw_cnt_q <= '0;
    end else begin
      if (issue_valid && raw_hz && raw_cnt_q != '1) raw_cnt_q <= raw_cnt_q + 32'd1;
      if (issue_valid && waw_hz && waw_cnt_q != '1) waw_cnt_q <= waw_cnt_q + 32'd1;
    end
  end

  assign perf_raw_stalls = raw_cnt_q;
  assign perf_waw_stalls = waw_cnt_q;
`endif
endmodule

// File: tb/tb_bypass_scoreboard.sv
// Self-checking bench: expectations queued while driving, drained against DUT outputs.
module tb_bypass_scoreboard;
  localparam int XLEN = 32, NSRC = 2, NBYP = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      issue_valid, issue_we, issue_long, flush, done_valid;
  logic [4:0]                issue_rd, done_rd;
  logic [NSRC-1:0][4:0]      issue_rs;
  logic [NSRC-1:0][XLEN-1:0] rf_data;
  logic [NBYP-1:0]           byp_valid, byp_ready;
  logic [NBYP-1:0][4:0]      byp_rd;
  logic [NBYP-1:0][XLEN-1:0] byp_data;
  logic [XLEN-1:0]           done_data;
  logic [NSRC-1:0][XLEN-1:0] opnd;
  logic                      stall;
  logic [31:0]               sb_busy;
`ifdef BYPASS_PERF_EN
  logic [31:0]               perf_raw_stalls, perf_waw_stalls;
`endif

  bypass_scoreboard #(.XLEN(XLEN), .NSRC(NSRC), .NBYP(NBYP)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_we(issue_we), .issue_long(issue_long), .issue_rs(issue_rs),
    .rf_data(rf_data), .byp_valid(byp_valid), .byp_ready(byp_ready),
    .byp_rd(byp_rd), .byp_data(byp_data), .done_valid(done_valid),
    .done_rd(done_rd), .done_data(done_data), .flush(flush),
    .opnd(opnd), .stall(stall), .sb_busy(sb_busy)
`ifdef BYPASS_PERF_EN
    , .perf_raw_stalls(perf_raw_stalls), .perf_waw_stalls(perf_waw_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {K_OP0, K_OP1, K_STALL, K_SB, K_PRAW, K_PWAW} kind_e;
  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [XLEN-1:0] RF0 = 32'hF0F0_0000;
  localparam logic [XLEN-1:0] RF1 = 32'h0F0F_1111;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sample(input kind_e k);
    case (k)
      K_OP0:   return opnd[0];
      K_OP1:   return opnd[1];
      K_STALL: return {31'b0, stall};
      K_SB:    return sb_busy;
`ifdef BYPASS_PERF_EN
      K_PRAW:  return perf_raw_stalls;
      K_PWAW:  return perf_waw_stalls;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_v(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  // Outputs are combinational; sample mid-cycle, well clear of the edge.
  task automatic drain();
    exp_t e;
    #2;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, sample(e.kind), e.val);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; issue_valid = 1'b0; issue_rd = '0; issue_we = 1'b0; issue_long = 1'b0;
    issue_rs = '0; flush = 1'b0; done_valid = 1'b0; done_rd = '0; done_data = '0;
    byp_valid = '0; byp_ready = '1; byp_rd = '0; byp_data = '0;
    rf_data[0] = RF0; rf_data[1] = RF1;
  endtask

  task automatic issue_long_op(input logic [4:0] rd);
    issue_valid = 1'b1; issue_we = 1'b1; issue_long = 1'b1; issue_rd = rd;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    next_cycle(); next_cycle();
    rst = 1'b0;

    // Reset state with a plain RF-sourced issue.
    next_cycle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 5'd1;
    issue_rs[0] = 5'd5; issue_rs[1] = 5'd6;
    expect_v("rst_op0", K_OP0, RF0);
    expect_v("rst_op1", K_OP1, RF1);
    expect_v("rst_stall", K_STALL, 0);
    expect_v("rst_sb", K_SB, 0);
`ifdef BYPASS_PERF_EN
    expect_v("rst_praw", K_PRAW, 0);
`endif
    drain();

    // Youngest matching channel wins.
    next_cycle(); idle();
    byp_valid = 3'b011; byp_rd[0] = 5'd7; byp_rd[1] = 5'd7;
    byp_data[0] = 32'hAAAA; byp_data[1] = 32'hBBBB; issue_rs[0] = 5'd7;
    expect_v("byp_young", K_OP0, 32'hAAAA);
    drain();

    // x0 never forwarded, even when a channel claims rd=0.
    next_cycle();
    byp_rd[0] = 5'd0; byp_data[0] = 32'hAAAA; issue_rs[1] = 5'd0;
    expect_v("x0_op1", K_OP1, 32'h0);
    expect_v("byp_older", K_OP0, 32'hBBBB);
    drain();

    // Completion port outranks bypass channels.
    next_cycle();
    done_valid = 1'b1; done_rd = 5'd7; done_data = 32'hCCCC;
    expect_v("done_prio", K_OP0, 32'hCCCC);
    expect_v("done_nb_sb", K_SB, 0);
    drain();

    // Load still in MEM: stall only while issuing.
    next_cycle(); idle();
    byp_valid = 3'b001; byp_ready = 3'b110; byp_rd[0] = 5'd9; issue_rs[0] = 5'd9;
    expect_v("ld_noissue", K_STALL, 0);
    drain();
    next_cycle();
    issue_valid = 1'b1;
    expect_v("ld_stall", K_STALL, 1);
    drain();
    next_cycle();
    byp_valid = 3'b010; byp_ready = 3'b111; byp_rd[1] = 5'd9; byp_data[1] = 32'h5555;
    expect_v("ld_fwd", K_OP0, 32'h5555);
    expect_v("ld_nostall", K_STALL, 0);
    drain();

    // Long mul to x12, then RAW on x12 until completion.
    next_cycle(); idle();
    issue_long_op(5'd12);
    expect_v("mul_issue", K_STALL, 0);
    drain();
    next_cycle(); idle();
    issue_valid = 1'b1; issue_rs[1] = 5'd12;
    expect_v("mul_sb", K_SB, 32'h1 << 12);
    expect_v("raw_stall", K_STALL, 1);
    drain();
    next_cycle();
    expect_v("raw_stall2", K_STALL, 1);
    drain();
    next_cycle();
    done_valid = 1'b1; done_rd = 5'd12; done_data = 32'h1234;
    expect_v("raw_done_st", K_STALL, 0);
    expect_v("raw_done_op", K_OP1, 32'h1234);
    drain();
    next_cycle(); idle();
    expect_v("mul_clr", K_SB, 0);
    drain();

    // WAW on x12; completion in the same cycle lets it fire and set wins.
    issue_long_op(5'd12);
    drain();
    next_cycle();
    expect_v("waw_stall", K_STALL, 1);
    drain();
    next_cycle();
    done_valid = 1'b1; done_rd = 5'd12;
    expect_v("waw_done_st", K_STALL, 0);
    drain();
    next_cycle(); idle();
    expect_v("set_wins", K_SB, 32'h1 << 12);
    done_valid = 1'b1; done_rd = 5'd12;
    drain();

    // Long op to x0 never marks busy.
    next_cycle(); idle();
    expect_v("x12_clr", K_SB, 0);
    issue_long_op(5'd0);
    drain();
    // Flushed long op leaves scoreboard alone.
    next_cycle(); idle();
    expect_v("x0_nobusy", K_SB, 0);
    issue_long_op(5'd5); flush = 1'b1;
    drain();
    next_cycle(); idle();
    expect_v("flush_nobusy", K_SB, 0);
    drain();

    // Busy x3 and x4, then reset mid-flight.
    issue_long_op(5'd3);
    next_cycle();
    issue_long_op(5'd4);
    next_cycle(); idle();
    expect_v("busy_3_4", K_SB, 32'h18);
    drain();
    rst = 1'b1;
    next_cycle(); idle();
    expect_v("rst_clear", K_SB, 0);
    done_valid = 1'b1; done_rd = 5'd3;
    drain();
    next_cycle(); idle();
    expect_v("late_done", K_SB, 0);
    drain();

`ifdef BYPASS_PERF_EN
    // Three RAW stall cycles from a not-ready load.
    issue_valid = 1'b1; byp_valid = 3'b001; byp_ready = 3'b000;
    byp_rd[0] = 5'd9; issue_rs[0] = 5'd9;
    next_cycle(); next_cycle(); next_cycle(); idle();
    expect_v("perf_raw", K_PRAW, 3);
    expect_v("perf_waw", K_PWAW, 0);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
